// File: rtl/cdb_rs.sv
// rtl/cdb_rs.sv - compacting reservation station with CDB wakeup (optional CDB_RS_BYPASS_EN dispatch bypass)
module cdb_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int ID_W  = 6,
    parameter int OP_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dis_req,
    output logic                       dis_rdy,
    input  logic [OP_W-1:0]            dis_op,
    input  logic [ID_W-1:0]            dis_inst_id,
    input  logic [TAG_W-1:0]           dis_rd_tag,
    input  logic                       dis_rs1_rdy,
    input  logic [TAG_W-1:0]           dis_rs1_tag,
    input  logic [31:0]                dis_rs1_val,
    input  logic                       dis_rs2_rdy,
    input  logic [TAG_W-1:0]           dis_rs2_tag,
    input  logic [31:0]                dis_rs2_val,
    input  logic                       cdb_wr,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_wdata,
    input  logic [ID_W-1:0]            cdb_inst_id,
    output logic                       iss_req,
    input  logic                       iss_rdy,
    output logic [OP_W-1:0]            iss_op,
    output logic [ID_W-1:0]            iss_inst_id,
    output logic [TAG_W-1:0]           iss_rd_tag,
    output logic [31:0]                iss_rs1_val,
    output logic [31:0]                iss_rs2_val,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] rd;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
    } entry_t;

    entry_t          q      [DEPTH];
    entry_t          woken  [DEPTH];
    entry_t          q_next [DEPTH];
    entry_t          dis_e;
    entry_t          sel_e;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   src;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   count_next;
    logic            iss_fire;
    logic            dis_fire;

    logic unused_inst_id;
    assign unused_inst_id = ^cdb_inst_id;

    assign dis_rdy  = (count < CW'(DEPTH)) && !flush;
    assign dis_fire = dis_req && dis_rdy;
    assign iss_fire = iss_req && iss_rdy;

    // Wakeup is computed on the stored entries so the woken value travels with any shift
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = q[i];
            if (cdb_wr && (CW'(i) < count)) begin
                if (!q[i].rs1_rdy && q[i].rs1_tag == cdb_tag) begin
                    woken[i].rs1_rdy = 1'b1;
                    woken[i].rs1_val = cdb_wdata;
                end
                if (!q[i].rs2_rdy && q[i].rs2_tag == cdb_tag) begin
                    woken[i].rs2_rdy = 1'b1;
                    woken[i].rs2_val = cdb_wdata;
                end
            end
        end
    end

    // Downward scan leaves the lowest ready index selected
    always_comb begin
        iss_req = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count) && q[i].rs1_rdy && q[i].rs2_rdy) begin
                iss_req = 1'b1;
                sel     = IW'(i);
            end
        end
        sel_e = iss_req ? q[sel] : '0;
    end

    assign iss_op      = sel_e.op;
    assign iss_inst_id = sel_e.id;
    assign iss_rd_tag  = sel_e.rd;
    assign iss_rs1_val = sel_e.rs1_val;
    assign iss_rs2_val = sel_e.rs2_val;

    always_comb begin
        dis_e = '{op: dis_op, id: dis_inst_id, rd: dis_rd_tag,
                  rs1_rdy: dis_rs1_rdy, rs1_tag: dis_rs1_tag, rs1_val: dis_rs1_val,
                  rs2_rdy: dis_rs2_rdy, rs2_tag: dis_rs2_tag, rs2_val: dis_rs2_val};
`ifdef CDB_RS_BYPASS_EN
        if (cdb_wr && !dis_rs1_rdy && dis_rs1_tag == cdb_tag) begin
            dis_e.rs1_rdy = 1'b1;
            dis_e.rs1_val = cdb_wdata;
        end
        if (cdb_wr && !dis_rs2_rdy && dis_rs2_tag == cdb_tag) begin
            dis_e.rs2_rdy = 1'b1;
            dis_e.rs2_val = cdb_wdata;
        end
`endif
    end

    assign wr_idx     = count - CW'(iss_fire);
    assign count_next = flush ? '0 : count + CW'(dis_fire) - CW'(iss_fire);

    always_comb begin
        src = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src = (iss_fire && IW'(i) >= sel && i < DEPTH - 1) ? IW'(i + 1) : IW'(i);
            q_next[i] = woken[src];
            if (dis_fire && CW'(i) == wr_idx)
                q_next[i] = dis_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
        end else begin
            count <= count_next;
            for (int i = 0; i < DEPTH; i++)
                q[i] <= q_next[i];
        end
    end
endmodule

// File: tb/tb_cdb_rs.sv
// tb/tb_cdb_rs.sv - directed self-checking bench for cdb_rs
module tb_cdb_rs;
    logic        clk = 1'b0;
    logic        rst_n, flush, dis_req, dis_rdy;
    logic [3:0]  dis_op;
    logic [5:0]  dis_inst_id, dis_rd_tag, dis_rs1_tag, dis_rs2_tag;
    logic        dis_rs1_rdy, dis_rs2_rdy;
    logic [31:0] dis_rs1_val, dis_rs2_val;
    logic        cdb_wr;
    logic [5:0]  cdb_tag, cdb_inst_id;
    logic [31:0] cdb_wdata;
    logic        iss_req, iss_rdy;
    logic [3:0]  iss_op;
    logic [5:0]  iss_inst_id, iss_rd_tag;
    logic [31:0] iss_rs1_val, iss_rs2_val;
    logic [2:0]  count;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    cdb_rs dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dis_req(dis_req), .dis_rdy(dis_rdy),
        .dis_op(dis_op), .dis_inst_id(dis_inst_id), .dis_rd_tag(dis_rd_tag),
        .dis_rs1_rdy(dis_rs1_rdy), .dis_rs1_tag(dis_rs1_tag), .dis_rs1_val(dis_rs1_val),
        .dis_rs2_rdy(dis_rs2_rdy), .dis_rs2_tag(dis_rs2_tag), .dis_rs2_val(dis_rs2_val),
        .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata), .cdb_inst_id(cdb_inst_id),
        .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_op(iss_op), .iss_inst_id(iss_inst_id),
        .iss_rd_tag(iss_rd_tag), .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; dis_req = 0; dis_op = 0; dis_inst_id = 0; dis_rd_tag = 0;
        dis_rs1_rdy = 0; dis_rs1_tag = 0; dis_rs1_val = 0;
        dis_rs2_rdy = 0; dis_rs2_tag = 0; dis_rs2_val = 0;
        cdb_wr = 0; cdb_tag = 0; cdb_wdata = 0; cdb_inst_id = 0;
    endtask

    task automatic set_dis(input logic [3:0] op, input logic r1, input logic [5:0] t1,
                           input logic [31:0] v1, input logic r2, input logic [5:0] t2,
                           input logic [31:0] v2);
        dis_req = 1; dis_op = op; dis_inst_id = {2'b0, op}; dis_rd_tag = {2'b1, op};
        dis_rs1_rdy = r1; dis_rs1_tag = t1; dis_rs1_val = v1;
        dis_rs2_rdy = r2; dis_rs2_tag = t2; dis_rs2_val = v2;
    endtask

    task automatic test_reset();
        rst_n = 0; iss_rdy = 0; idle();
        tick(); tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (iss_req !== 1'b0) begin miscompares++; $display("FAIL reset_iss_req got=%b exp=0", iss_req); end
        vectors++; if (iss_rs1_val !== 32'h0 || iss_op !== 4'h0) begin miscompares++; $display("FAIL reset_iss_fields got=%h/%h exp=0/0", iss_rs1_val, iss_op); end
        rst_n = 1; #1;
        vectors++; if (dis_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_dis_rdy got=%b exp=1", dis_rdy); end
    endtask

    task automatic test_basic();
        iss_rdy = 1;
        set_dis(4'd1, 1, 6'd0, 32'h5, 1, 6'd0, 32'h7);
        tick();
        dis_req = 0;
        vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL basic_count1 got=%0d exp=1", count); end
        vectors++; if (iss_req !== 1'b1) begin miscompares++; $display("FAIL basic_iss_req got=%b exp=1", iss_req); end
        vectors++; if (iss_rs1_val !== 32'h5 || iss_rs2_val !== 32'h7) begin miscompares++; $display("FAIL basic_vals got=%h/%h exp=5/7", iss_rs1_val, iss_rs2_val); end
        vectors++; if (iss_rd_tag !== 6'h11 || iss_inst_id !== 6'h01) begin miscompares++; $display("FAIL basic_tags got=%h/%h exp=11/01", iss_rd_tag, iss_inst_id); end
        tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    endtask

    task automatic test_wakeup();
        iss_rdy = 1;
        set_dis(4'd2, 0, 6'd3, 32'h0, 1, 6'd0, 32'h11);
        tick();
        dis_req = 0;
        vectors++; if (count !== 3'd1 || iss_req !== 1'b0) begin miscompares++; $display("FAIL wake_wait got=%0d/%b exp=1/0", count, iss_req); end
        cdb_wr = 1; cdb_tag = 6'd4; cdb_wdata = 32'hBEEF;
        tick();
        vectors++; if (iss_req !== 1'b0) begin miscompares++; $display("FAIL wake_wrong_tag got=%b exp=0", iss_req); end
        cdb_tag = 6'd3; cdb_wdata = 32'hDEAD; cdb_inst_id = 6'h3F;
        tick();
        cdb_wr = 0;
        vectors++; if (iss_req !== 1'b1 || iss_rs1_val !== 32'hDEAD) begin miscompares++; $display("FAIL wake_issue got=%b/%h exp=1/dead", iss_req, iss_rs1_val); end
        tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL wake_drain got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        iss_rdy = 0; idle();
        for (int k = 1; k <= 4; k++) begin
            set_dis(4'(k), 1, 6'd0, 32'(k), 1, 6'd0, 32'h0);
            tick();
        end
        set_dis(4'd5, 1, 6'd0, 32'h5, 1, 6'd0, 32'h0);
        vectors++; if (count !== 3'd4 || dis_rdy !== 1'b0) begin miscompares++; $display("FAIL full_state got=%0d/%b exp=4/0", count, dis_rdy); end
        vectors++; if (iss_op !== 4'd1) begin miscompares++; $display("FAIL full_oldest got=%0d exp=1", iss_op); end
        iss_rdy = 1;
        tick();
        vectors++; if (count !== 3'd3 || iss_op !== 4'd2) begin miscompares++; $display("FAIL full_issue_nodis got=%0d/%0d exp=3/2", count, iss_op); end
        iss_rdy = 0;
        tick();
        dis_req = 0;
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_refill got=%0d exp=4", count); end
        iss_rdy = 1;
        for (int k = 2; k <= 5; k++) begin
            vectors++; if (iss_op !== 4'(k)) begin miscompares++; $display("FAIL full_order got=%0d exp=%0d", iss_op, k); end
            tick();
        end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL full_drain got=%0d exp=0", count); end
    endtask

    task automatic test_order();
        iss_rdy = 0;
        set_dis(4'd1, 1, 6'd0, 32'h1, 1, 6'd0, 32'h1); tick();
        set_dis(4'd2, 1, 6'd0, 32'h2, 0, 6'd5, 32'h0); tick();
        set_dis(4'd3, 1, 6'd0, 32'h3, 1, 6'd0, 32'h3); tick();
        dis_req = 0;
        vectors++; if (count !== 3'd3 || iss_op !== 4'd1) begin miscompares++; $display("FAIL order_first got=%0d/%0d exp=3/1", count, iss_op); end
        iss_rdy = 1;
        tick();
        vectors++; if (iss_op !== 4'd3) begin miscompares++; $display("FAIL order_skip got=%0d exp=3", iss_op); end
        tick();
        vectors++; if (count !== 3'd1 || iss_req !== 1'b0) begin miscompares++; $display("FAIL order_wait got=%0d/%b exp=1/0", count, iss_req); end
        iss_rdy = 0; cdb_wr = 1; cdb_tag = 6'd5; cdb_wdata = 32'h55;
        tick();
        cdb_wr = 0;
        vectors++; if (iss_op !== 4'd2 || iss_rs2_val !== 32'h55) begin miscompares++; $display("FAIL order_woken got=%0d/%h exp=2/55", iss_op, iss_rs2_val); end
        iss_rdy = 1;
        tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL order_drain got=%0d exp=0", count); end
    endtask

    task automatic test_wake_shift();
        iss_rdy = 0;
        set_dis(4'd6, 1, 6'd0, 32'h6, 1, 6'd0, 32'h6); tick();
        set_dis(4'd7, 0, 6'd7, 32'h0, 1, 6'd0, 32'h7); tick();
        dis_req = 0; iss_rdy = 1; cdb_wr = 1; cdb_tag = 6'd7; cdb_wdata = 32'h77;
        tick();
        cdb_wr = 0;
        vectors++; if (iss_req !== 1'b1 || iss_op !== 4'd7 || iss_rs1_val !== 32'h77) begin miscompares++; $display("FAIL shift_wake got=%b/%0d/%h exp=1/7/77", iss_req, iss_op, iss_rs1_val); end
        tick();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL shift_drain got=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        iss_rdy = 1;
        set_dis(4'd9, 1, 6'd1, 32'h1, 0, 6'd9, 32'h0);
        cdb_wr = 1; cdb_tag = 6'd9; cdb_wdata = 32'h42;
        tick();
        dis_req = 0; cdb_wr = 0;
`ifdef CDB_RS_BYPASS_EN
        vectors++; if (iss_req !== 1'b1 || iss_rs2_val !== 32'h42) begin miscompares++; $display("FAIL bypass_on got=%b/%h exp=1/42", iss_req, iss_rs2_val); end
`else
        vectors++; if (iss_req !== 1'b0 || count !== 3'd1) begin miscompares++; $display("FAIL bypass_off got=%b/%0d exp=0/1", iss_req, count); end
`endif
        flush = 1;
        tick();
        flush = 0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL bypass_cleanup got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        iss_rdy = 0;
        for (int k = 1; k <= 3; k++) begin
            set_dis(4'(k), 1, 6'd0, 32'h0, 1, 6'd0, 32'h0);
            tick();
        end
        flush = 1; #1;
        vectors++; if (dis_rdy !== 1'b0) begin miscompares++; $display("FAIL flush_dis_rdy got=%b exp=0", dis_rdy); end
        tick();
        flush = 0; dis_req = 0; #1;
        vectors++; if (count !== 3'd0 || iss_req !== 1'b0) begin miscompares++; $display("FAIL flush_clear got=%0d/%b exp=0/0", count, iss_req); end
        vectors++; if (dis_rdy !== 1'b1) begin miscompares++; $display("FAIL flush_recover got=%b exp=1", dis_rdy); end
        set_dis(4'd1, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0); tick();
        set_dis(4'd2, 1, 6'd0, 32'h0, 1, 6'd0, 32'h0); tick();
        dis_req = 0;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL midfill_count got=%0d exp=2", count); end
        #2 rst_n = 0; #1;
        vectors++; if (count !== 3'd0 || iss_req !== 1'b0) begin miscompares++; $display("FAIL midfill_reset got=%0d/%b exp=0/0", count, iss_req); end
        #1 rst_n = 1;
        tick();
        vectors++; if (count !== 3'd0 || dis_rdy !== 1'b1) begin miscompares++; $display("FAIL post_reset got=%0d/%b exp=0/1", count, dis_rdy); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_order();
        test_wake_shift();
        test_bypass();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cdb_rs.md
CDB_RS -- requirements
Module: cdb_rs

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries (power of two, 2..8).
REQ-002 Parameter TAG_W, default 6, physical-register tag width.
REQ-003 Parameter ID_W, default 6, instruction-id width.
REQ-004 Parameter OP_W, default 4, opcode width; XLEN fixed at 32.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  discard all entries.
REQ-008 dis_req / dis_rdy  in / out  1 / 1  dispatch handshake; transfer on dis_req && dis_rdy.
REQ-009 dis_op, dis_inst_id, dis_rd_tag  in  OP_W, ID_W, TAG_W  dispatched operation fields.
REQ-010 dis_rsN_rdy, dis_rsN_tag, dis_rsN_val (N=1,2)  in  1, TAG_W, 32  operand readiness, producer tag, value.
REQ-011 cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id  in  1, TAG_W, 32, ID_W  CDB broadcast snoop.
REQ-012 iss_req / iss_rdy  out / in  1 / 1  issue handshake to execution unit; transfer on iss_req && iss_rdy.
REQ-013 iss_op, iss_inst_id, iss_rd_tag, iss_rs1_val, iss_rs2_val  out  OP_W, ID_W, TAG_W, 32, 32  issued operation.
REQ-014 count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Entries SHALL form a compacting queue; entry 0 oldest; valid entries occupy indices 0..count-1.
REQ-016 dis_rdy SHALL be (count < DEPTH) && !flush, independent of iss_rdy (no same-cycle free-slot reuse when full).
REQ-017 Accepted dispatch SHALL be written at index count minus 1 if an issue transfers in the same cycle, else at index count.
REQ-018 Wakeup: for every valid entry with operand not ready and cdb_wr=1 with cdb_tag equal to its tag, operand SHALL capture cdb_wdata and become ready at the clock edge; both operands may wake in one cycle.
REQ-019 Wakeup SHALL apply to entry contents before compaction; the woken value moves with the entry.
REQ-020 iss_req SHALL be 1 when any valid entry has both operands ready; the selected entry is the lowest-index such entry; iss_* fields SHALL be driven combinationally from that entry's registered contents.
REQ-021 Wakeup-to-issue latency: CDB broadcast in cycle N, earliest iss_req for that entry in cycle N+1.
REQ-022 On issue transfer, selected entry SHALL be removed and all higher entries shift down by one, preserving order.
REQ-023 iss_* fields SHALL hold stable while iss_req=1 and iss_rdy=0, unless a new older entry becomes ready (allowed to change selection).
REQ-024 flush SHALL clear all valid bits at the next edge; a same-cycle dispatch is refused (dis_rdy=0), a same-cycle issue transfer still completes; count=0 next cycle.
REQ-025 count SHALL equal count + dispatch transfer - issue transfer (0 after flush), never exceeding DEPTH.
REQ-026 cdb_inst_id is ignored for matching; match uses tag only.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all valid and ready bits; count=0, dis_rdy=1 after release, iss_req=0, iss_* fields 0.
REQ-028 Reset mid-operation SHALL discard all entries without issuing; no transfer occurs while rst_n=0.

Configuration
REQ-029 Macro CDB_RS_BYPASS_EN defined: a dispatched operand with dis_rsN_rdy=0 whose tag matches a same-cycle CDB broadcast SHALL be stored ready with cdb_wdata.
REQ-030 CDB_RS_BYPASS_EN undefined: dispatched operand fields are stored exactly as presented; the dispatch stage is responsible for same-cycle CDB forwarding.

Verification
REQ-031 Reset, dispatch op with rs1 ready=0x5, rs2 ready=0x7, iss_rdy=1 -> iss_req next cycle, iss_rs1_val=0x5, iss_rs2_val=0x7, count 1->0.
REQ-032 Dispatch with rs1 tag 3 not ready; cycle N cdb_wr=1 tag 3 data 0xDEAD -> iss_req=1 in N+1, iss_rs1_val=0xDEAD; tag 4 broadcast -> no wakeup.
REQ-033 Fill 4 entries, iss_rdy=0 -> count=4, dis_rdy=0; iss_rdy=1 with dis_req=1 in the same cycle -> one issue transfer, no dispatch, count=3; dispatch accepted next cycle, count=4.
REQ-034 Entries 0 and 2 ready, entry 1 waiting -> entry 0 issues, then entry 2; entry 1 keeps index order after compaction and issues after its wakeup.
REQ-035 With bypass enabled: dispatch rs2 tag 9 not ready with same-cycle cdb tag 9 data 0x42 -> iss_rs2_val=0x42 next cycle; with bypass disabled -> entry waits.
REQ-036 flush with 3 entries and dis_req=1 -> dis_rdy=0, count=0 next cycle, iss_req=0; assert rst_n low mid-fill -> count=0 immediately.
